// File: rtl/cfar_door_sched_pkg.sv
// Shared types and defaults for the CFAR door scheduler: FSM state encoding
// and the default channel count / datapath width.
package cfar_door_sched_pkg;

    localparam int CFAR_N_CH = 4;
    localparam int CFAR_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_CALC = 3'b010,
        ST_WB   = 3'b100
    } state_t;

endpackage

// File: rtl/cfar_door_sched_rr_arb.sv
// Combinational rotate-priority arbiter: searches last_grant+1, +2, ... (mod N_CH)
// and returns the first requesting channel.
module cfar_rr_arb
    import cfar_door_sched_pkg::*;
#(
    parameter int N_CH = CFAR_N_CH,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   last_grant,
    output logic [CW-1:0]   grant,
    output logic            gnt_valid
);

    always_comb begin
        grant     = '0;
        gnt_valid = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!gnt_valid && req[(int'(last_grant) + k) % N_CH]) begin
                grant     = CW'((int'(last_grant) + k) % N_CH);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfar_door_sched.sv
// Time-shares one saturating door-update engine among N_CH CFAR channels.
// Round-robin grant, three-cycle update (grant, compute, write-back + ack).
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | apply load/pending load, else grant next requesting channel
//   ST_CALC | compute saturated next door for the granted channel
//   ST_WB   | write door back, pulse ack/upd_valid, remember last grant
module cfar_door_sched
    import cfar_door_sched_pkg::*;
#(
    parameter int N_CH = CFAR_N_CH,
    parameter int W    = CFAR_W,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      init_door,
    input  logic [W-1:0]      error,
    input  logic [W-1:0]      step,
    input  logic              load,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH*W-1:0] cnt_flat,
    output logic [N_CH-1:0]   ack,
    output logic [N_CH*W-1:0] door_flat,
    output logic              busy,
    output logic [CW-1:0]     upd_ch,
    output logic              upd_valid
);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    door    [N_CH];
    logic [W-1:0]    cnt_arr [N_CH];
    logic [CW-1:0]   ch_r;
    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   grant;
    logic            gnt_valid;
    logic [W-1:0]    cnt_r;
    logic [W-1:0]    nxt_r;
    logic [W-1:0]    door_cur;
    logic [W-1:0]    calc_val;
    logic [W:0]      sum;
    logic [N_CH-1:0] req_open;
    logic            load_any;
    logic            load_pend;

    for (genvar i = 0; i < N_CH; i++) begin : g_flat
        assign door_flat[i*W +: W] = door[i];
        assign cnt_arr[i]          = cnt_flat[i*W +: W];
    end

    // The channel being acked this cycle is still holding req; mask it so it
    // is not granted a second time.
    assign req_open = req & ~ack;
    assign load_any = load | load_pend;
    assign door_cur = door[ch_r];

    cfar_rr_arb #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_arb (
        .req        (req_open),
        .last_grant (last_grant),
        .grant      (grant),
        .gnt_valid  (gnt_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!load_any && gnt_valid) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                busy      = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // W+1-bit sum catches overflow; subtraction clamps at zero.
    always_comb begin
        sum      = {1'b0, door_cur} + {1'b0, step};
        calc_val = door_cur;
        if (cnt_r > error) begin
            calc_val = sum[W] ? '1 : sum[W-1:0];
        end else if (cnt_r < error) begin
            calc_val = (step > door_cur) ? '0 : door_cur - step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                door[i] <= '0;
            end
            ack        <= '0;
            upd_valid  <= 1'b0;
            upd_ch     <= '0;
            last_grant <= CW'(N_CH - 1);
            load_pend  <= 1'b0;
            ch_r       <= '0;
            cnt_r      <= '0;
            nxt_r      <= '0;
        end else begin
            ack       <= '0;
            upd_valid <= 1'b0;
            if (load && state != ST_IDLE) begin
                load_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (load_any) begin
                        for (int i = 0; i < N_CH; i++) begin
                            door[i] <= init_door;
                        end
                        load_pend <= 1'b0;
                    end else if (gnt_valid) begin
                        ch_r  <= grant;
                        cnt_r <= cnt_arr[grant];
                    end
                end
                ST_CALC: begin
                    nxt_r <= calc_val;
                end
                ST_WB: begin
                    door[ch_r] <= nxt_r;
                    ack[ch_r]  <= 1'b1;
                    upd_valid  <= 1'b1;
                    upd_ch     <= ch_r;
                    last_grant <= ch_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfar_door_sched.sv
// Self-checking bench for cfar_door_sched: directed scenarios plus randomized
// request bursts checked against a plain-arithmetic model of doors and grant order.
module tb_cfar_door_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [W-1:0]    init_door = '0;
    logic [W-1:0]    error = '0;
    logic [W-1:0]    step = '0;
    logic            load = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  cnt_flat = '0;
    logic [N-1:0]    ack;
    logic [N*W-1:0]  door_flat;
    logic            busy;
    logic [CW-1:0]   upd_ch;
    logic            upd_valid;

    int n_pass  = 0;
    int n_total = 0;
    int m_door [N];
    int m_lg;

    cfar_door_sched #(.N_CH(N), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .init_door (init_door),
        .error     (error),
        .step      (step),
        .load      (load),
        .req       (req),
        .cnt_flat  (cnt_flat),
        .ack       (ack),
        .door_flat (door_flat),
        .busy      (busy),
        .upd_ch    (upd_ch),
        .upd_valid (upd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_update(int d, int c, int e, int s);
        int r;
        r = d;
        if (c > e) r = (d + s > 65535) ? 65535 : d + s;
        else if (c < e) r = (s > d) ? 0 : d - s;
        return r;
    endfunction

    function automatic int rr_next(logic [N-1:0] set, int lg);
        for (int k = 1; k <= N; k++) begin
            if (set[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    function automatic int door_of(int i);
        return int'(door_flat[i*W +: W]);
    endfunction

    task automatic set_cnt(input int ch, input int v);
        cnt_flat[ch*W +: W] = 16'(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_door[i] = 0;
        m_lg = N - 1;
    endtask

    task automatic model_load(input int v);
        for (int i = 0; i < N; i++) m_door[i] = v;
    endtask

    task automatic wait_ack(output int ch, output int lat);
        ch  = -1;
        lat = 0;
        while (ch < 0 && lat < 40) begin
            tick();
            lat++;
            for (int i = 0; i < N; i++) if (ack[i]) ch = i;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_total++;
        if (ack !== 4'b0 || upd_valid !== 1'b0 || busy !== 1'b0 || upd_ch !== 2'd0)
            $display("FAIL reset_outputs: ack=%b upd_valid=%b busy=%b upd_ch=%0d, want all 0", ack, upd_valid, busy, upd_ch);
        else n_pass++;
        n_total++;
        if (door_flat !== '0) $display("FAIL reset_doors: door_flat=%h want 0", door_flat);
        else n_pass++;
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_load();
        init_door = 16'h0100;
        load = 1'b1;
        tick();
        load = 1'b0;
        model_load(16'h0100);
        n_total++;
        if (door_flat !== {4{16'h0100}}) $display("FAIL load_doors: door_flat=%h want 0100 x4", door_flat);
        else n_pass++;
        n_total++;
        if (ack !== 4'b0 || busy !== 1'b0) $display("FAIL load_idle: ack=%b busy=%b want 0/0", ack, busy);
        else n_pass++;
    endtask

    task automatic test_update();
        int cnts [3] = '{60, 40, 50};
        int got, lat, c, v, exp_d;
        error = 16'd50;
        step  = 16'd4;
        foreach (cnts[k]) begin
            set_cnt(1, cnts[k]);
            req[1] = 1'b1;
            tick();
            tick();
            n_total++;
            if (ack !== 4'b0 || busy !== 1'b1) $display("FAIL upd_early cnt=%0d: ack=%b busy=%b want 0000/1", cnts[k], ack, busy);
            else n_pass++;
            tick();
            exp_d = m_update(m_door[1], cnts[k], 50, 4);
            m_door[1] = exp_d;
            m_lg = 1;
            n_total++;
            if (ack !== 4'b0010 || upd_valid !== 1'b1 || upd_ch !== 2'd1)
                $display("FAIL upd_ack cnt=%0d: ack=%b upd_valid=%b upd_ch=%0d want 0010/1/1", cnts[k], ack, upd_valid, upd_ch);
            else n_pass++;
            n_total++;
            if (door_of(1) !== exp_d || door_of(0) !== m_door[0] || door_of(2) !== m_door[2])
                $display("FAIL upd_door cnt=%0d: door_flat=%h want door1=%h", cnts[k], door_flat, exp_d);
            else n_pass++;
            tick();
            req[1] = 1'b0;
            n_total++;
            if (ack !== 4'b0 || busy !== 1'b0 || upd_valid !== 1'b0)
                $display("FAIL upd_pulse cnt=%0d: ack=%b busy=%b upd_valid=%b want 0/0/0", cnts[k], ack, busy, upd_valid);
            else n_pass++;
        end
        for (int it = 0; it < 6; it++) begin
            c = $urandom_range(0, N - 1);
            v = $urandom_range(0, 100);
            step = 16'($urandom_range(0, 300));
            set_cnt(c, v);
            req[c] = 1'b1;
            wait_ack(got, lat);
            exp_d = m_update(m_door[c], v, 50, int'(step));
            m_door[c] = exp_d;
            m_lg = c;
            n_total++;
            if (got !== c || lat !== 3 || door_of(c) !== exp_d)
                $display("FAIL upd_rand ch=%0d: got ch=%0d lat=%0d door=%h want ch=%0d lat=3 door=%h", c, got, lat, door_of(c), c, exp_d);
            else n_pass++;
            tick();
            req = '0;
        end
    endtask

    task automatic run_burst(input logic [N-1:0] set, input string tag);
        logic [N-1:0] pend;
        int got, lat, exp_c, exp_d, n;
        pend = set;
        n = $countones(set);
        for (int i = 0; i < N; i++) set_cnt(i, $urandom_range(0, 200));
        req = set;
        for (int j = 0; j < n; j++) begin
            exp_c = rr_next(pend, m_lg);
            wait_ack(got, lat);
            exp_d = m_update(m_door[exp_c], int'(cnt_flat[exp_c*W +: W]), int'(error), int'(step));
            m_door[exp_c] = exp_d;
            m_lg = exp_c;
            pend[exp_c] = 1'b0;
            n_total++;
            if (got !== exp_c || lat !== ((j == 0) ? 3 : 2) || !$onehot(ack))
                $display("FAIL %s_order #%0d: ch=%0d lat=%0d ack=%b want ch=%0d lat=%0d", tag, j, got, lat, ack, exp_c, (j == 0) ? 3 : 2);
            else n_pass++;
            n_total++;
            if (door_of(exp_c) !== exp_d)
                $display("FAIL %s_door #%0d: door%0d=%h want %h", tag, j, exp_c, door_of(exp_c), exp_d);
            else n_pass++;
            tick();
            if (got < 0) begin
                req = '0;
                break;
            end
            req[got] = 1'b0;
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] set;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        error = 16'd50;
        step  = 16'd4;
        run_burst(4'b1111, "rr_all");
        run_burst(4'b0101, "rr_02");
        for (int b = 0; b < 8; b++) begin
            set   = 4'($urandom_range(1, 15));
            error = 16'($urandom_range(0, 200));
            step  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 500));
            run_burst(set, "rr_rand");
        end
    endtask

    task automatic test_saturation();
        int got, lat;
        error = 16'd50;
        step  = 16'd4;
        init_door = 16'hFFFE;
        load = 1'b1;
        tick();
        load = 1'b0;
        set_cnt(0, 60);
        req[0] = 1'b1;
        wait_ack(got, lat);
        n_total++;
        if (got !== 0 || door_of(0) !== 16'hFFFF) $display("FAIL sat_high: ch=%0d door0=%h want ch=0 door=ffff", got, door_of(0));
        else n_pass++;
        tick();
        req = '0;
        init_door = 16'h0002;
        load = 1'b1;
        tick();
        load = 1'b0;
        set_cnt(2, 10);
        req[2] = 1'b1;
        wait_ack(got, lat);
        n_total++;
        if (got !== 2 || door_of(2) !== 16'h0000) $display("FAIL sat_low: ch=%0d door2=%h want ch=2 door=0000", got, door_of(2));
        else n_pass++;
        tick();
        req = '0;
        model_load(2);
        m_door[0] = 2;
        m_door[2] = 0;
        m_lg = 2;
    endtask

    task automatic test_load_pending();
        int got, lat, exp3;
        error = 16'd50;
        step  = 16'd4;
        init_door = 16'h0300;
        set_cnt(3, 60);
        req[3] = 1'b1;
        tick();
        load = 1'b1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL lp_busy: busy=%b want 1", busy);
        else n_pass++;
        tick();
        load = 1'b0;
        set_cnt(1, 40);
        req[1] = 1'b1;
        tick();
        exp3 = m_update(m_door[3], 60, 50, 4);
        n_total++;
        if (ack !== 4'b1000 || door_of(3) !== exp3) $display("FAIL lp_ack3: ack=%b door3=%h want 1000/%h", ack, door_of(3), exp3);
        else n_pass++;
        tick();
        req[3] = 1'b0;
        model_load(16'h0300);
        m_lg = 3;
        n_total++;
        if (door_flat !== {4{16'h0300}} || ack !== 4'b0 || busy !== 1'b0)
            $display("FAIL lp_apply: door_flat=%h ack=%b busy=%b want 0300 x4/0000/0", door_flat, ack, busy);
        else n_pass++;
        wait_ack(got, lat);
        m_door[1] = m_update(16'h0300, 40, 50, 4);
        m_lg = 1;
        n_total++;
        if (got !== 1 || lat !== 3 || door_of(1) !== m_door[1])
            $display("FAIL lp_after: ch=%0d lat=%0d door1=%h want ch=1 lat=3 door=%h", got, lat, door_of(1), m_door[1]);
        else n_pass++;
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_reset_midop();
        int got, lat;
        error = 16'd50;
        step  = 16'd4;
        set_cnt(0, 60);
        req[0] = 1'b1;
        tick();
        tick();
        set_cnt(2, 60);
        req[2] = 1'b1;
        reset = 1'b0;
        #1;
        n_total++;
        if (ack !== 4'b0 || door_flat !== '0 || busy !== 1'b0)
            $display("FAIL rst_mid: ack=%b door_flat=%h busy=%b want 0/0/0", ack, door_flat, busy);
        else n_pass++;
        req[0] = 1'b0;
        tick();
        n_total++;
        if (ack !== 4'b0 || upd_valid !== 1'b0) $display("FAIL rst_noack: ack=%b upd_valid=%b want 0/0", ack, upd_valid);
        else n_pass++;
        reset = 1'b1;
        model_reset();
        wait_ack(got, lat);
        n_total++;
        if (got !== 2 || lat !== 3 || door_of(2) !== m_update(0, 60, 50, 4))
            $display("FAIL rst_resume: ch=%0d lat=%0d door2=%h want ch=2 lat=3 door=%h", got, lat, door_of(2), m_update(0, 60, 50, 4));
        else n_pass++;
        tick();
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_update();
        test_round_robin();
        test_saturation();
        test_load_pending();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
